// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
// Pure declarations, no logic.
// Imported by the sequencer and by anything that models the shared ALU.
package alu_seq_pkg;

    typedef enum logic {
        OP_MUL  = 1'b0,
        OP_UDIV = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL_STEP,
        DIV_STEP,
        DONE
    } state_e;

    localparam logic [1:0] ALUCTL_ADD = 2'b00;
    localparam logic [1:0] ALUCTL_SUB = 2'b01;
    localparam logic [1:0] ALUCTL_AND = 2'b10;
    localparam logic [1:0] ALUCTL_ORR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencer running unsigned 32x32 multiply (low word) and restoring 32/32 divide on the shared ALU.
// Latency: WIDTH+1 cycles from accepted start to done; divide-by-zero finishes in one cycle.
// Backpressure: start is only sampled in IDLE; requests while busy or done are dropped.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [1:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // Only the carry flag matters: it is the no-borrow indication of the trial subtract.
    logic unused_flags;
    assign unused_flags = alu_flags[FLAG_N] ^ alu_flags[FLAG_Z] ^ alu_flags[FLAG_V];

    // Next-state and ALU drive; ALU inputs depend only on registered state.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        alu_srca    = '0;
        alu_srcb    = '0;
        alu_control = ALUCTL_ADD;
        trial       = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        rem_nxt     = trial;
        quo_nxt     = {quo_q[WIDTH-2:0], 1'b0};

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == OP_UDIV) begin
                        if (b == '0) begin
                            result_d    = '1;
                            remainder_d = a;
                            dbz_d       = 1'b1;
                            state_d     = DONE;
                        end else begin
                            rem_d   = '0;
                            quo_d   = a;
                            dvsr_d  = b;
                            cnt_d   = '0;
                            dbz_d   = 1'b0;
                            state_d = DIV_STEP;
                        end
                    end else begin
                        acc_d    = '0;
                        mcand_d  = a;
                        mplier_d = b;
                        cnt_d    = '0;
                        dbz_d    = 1'b0;
                        state_d  = MUL_STEP;
                    end
                end
            end
            MUL_STEP: begin
                alu_srca    = acc_q;
                alu_srcb    = mplier_q[0] ? mcand_q : '0;
                alu_control = ALUCTL_ADD;
                acc_d       = alu_result;
                mcand_d     = mcand_q << 1;
                mplier_d    = mplier_q >> 1;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    result_d    = alu_result;
                    remainder_d = '0;
                    state_d     = DONE;
                end
            end
            DIV_STEP: begin
                alu_srca    = trial;
                alu_srcb    = dvsr_q;
                alu_control = ALUCTL_SUB;
                if (alu_flags[FLAG_C]) begin
                    rem_nxt = alu_result;
                    quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
                end
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    result_d    = quo_nxt;
                    remainder_d = rem_nxt;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset mid-operation aborts without done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == MUL_STEP) || (state_q == DIV_STEP);
    assign done        = (state_q == DONE);
    assign result      = result_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural model of the shared ALU on the alu_* ports.
// Inputs are driven and outputs sampled on the falling edge.
// Every expected value below is hand-computed.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic [31:0] alu_srca;
    logic [31:0] alu_srcb;
    logic [1:0]  alu_control;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;

    int n_pass;
    int n_checks;

    alu_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .alu_srca    (alu_srca),
        .alu_srcb    (alu_srcb),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: add/sub with ARM-style flags (C = carry out, i.e. no borrow on sub).
    logic [31:0] alu_b_eff;
    logic [32:0] alu_sum;
    logic        alu_c;
    logic        alu_v;
    always_comb begin
        alu_b_eff  = (alu_control == ALUCTL_SUB) ? ~alu_srcb : alu_srcb;
        alu_sum    = {1'b0, alu_srca} + {1'b0, alu_b_eff} + {32'd0, (alu_control == ALUCTL_SUB)};
        alu_result = alu_sum[31:0];
        alu_c      = alu_sum[32];
        alu_v      = (alu_srca[31] == alu_b_eff[31]) && (alu_sum[31] != alu_srca[31]);
        if (alu_control == ALUCTL_AND) begin
            alu_result = alu_srca & alu_srcb;
            alu_c      = 1'b0;
            alu_v      = 1'b0;
        end else if (alu_control == ALUCTL_ORR) begin
            alu_result = alu_srca | alu_srcb;
            alu_c      = 1'b0;
            alu_v      = 1'b0;
        end
        alu_flags = {alu_result[31], (alu_result == 32'd0), alu_c, alu_v};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one op, wait (bounded) for done, then check latency, outputs and pulse width.
    // poke >= 0 re-asserts start (UDIV 1/1) that many cycles into the run; it must be ignored.
    task automatic run_op(input string tag, input logic o, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] er, input logic [31:0] erem, input logic edbz,
                          input int elat, input logic [1:0] ectl, input int poke);
        int lat;
        @(negedge clk);
        start = 1'b1; op = o; a = ia; b = ib;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 0) begin
                check({tag, ".busy0"}, {31'd0, busy}, 32'd1);
                check({tag, ".ctl0"}, {30'd0, alu_control}, {30'd0, ectl});
            end
            if (lat == poke) begin
                start = 1'b1; op = OP_UDIV; a = 32'd1; b = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, ".lat"}, 32'(lat), 32'(elat));
        check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, ".result"}, result, er);
        check({tag, ".rem"}, remainder, erem);
        check({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
        @(negedge clk);
        check({tag, ".done_width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int idx[3];
        int nd;
        logic prev_done;

        n_pass = 0; n_checks = 0;
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.rem", remainder, 32'd0);
        check("rst.dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst.srca", alu_srca, 32'd0);
        check("rst.srcb", alu_srcb, 32'd0);
        check("rst.ctl", {30'd0, alu_control}, 32'd0);
        reset = 1'b0;

        // Multiply: 7*6; max*max wraps to 1 and an in-flight start is ignored
        run_op("mul7x6", OP_MUL, 32'd7, 32'd6, 32'h0000002A, 32'd0, 1'b0, 32, ALUCTL_ADD, -1);
        run_op("mulmax", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'd0, 1'b0, 32, ALUCTL_ADD, 5);

        // Divide
        run_op("div100_7", OP_UDIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, ALUCTL_SUB, -1);
        run_op("divbig", OP_UDIV, 32'hFFFFFFFF, 32'h80000001, 32'd1, 32'h7FFFFFFE, 1'b0, 32, ALUCTL_SUB, -1);

        // Divide by zero finishes in one cycle; next op clears the sticky flag
        run_op("div0", OP_UDIV, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 0, ALUCTL_ADD, -1);
        run_op("mul3x3", OP_MUL, 32'd3, 32'd3, 32'd9, 32'd0, 1'b0, 32, ALUCTL_ADD, -1);

        // Reset during step 10 of a divide
        @(negedge clk);
        start = 1'b1; op = OP_UDIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.done", {31'd0, done}, 32'd0);
        check("abort.result", result, 32'd0);
        check("abort.rem", remainder, 32'd0);
        check("abort.srca", alu_srca, 32'd0);
        check("abort.srcb", alu_srcb, 32'd0);
        check("abort.ctl", {30'd0, alu_control}, 32'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort.no_done", 32'(nd), 32'd0);
        run_op("mul2x3", OP_MUL, 32'd2, 32'd3, 32'd6, 32'd0, 1'b0, 32, ALUCTL_ADD, -1);

        // Back-to-back with start held high: DONE, IDLE, 32 steps -> 34 cycles apart
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 32'd2; b = 32'd5;
        nd = 0;
        prev_done = 1'b0;
        for (int i = 0; i < 130 && nd < 3; i++) begin
            @(negedge clk);
            if (prev_done) check("b2b.done_width", {31'd0, done}, 32'd0);
            if (done) begin
                idx[nd] = i;
                nd++;
                check("b2b.result", result, 32'd10);
            end
            prev_done = done;
        end
        start = 1'b0;
        check("b2b.count", 32'(nd), 32'd3);
        if (nd == 3) begin
            check("b2b.gap1", 32'(idx[1] - idx[0]), 32'd34);
            check("b2b.gap2", 32'(idx[2] - idx[1]), 32'd34);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
